// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose
//   Lets the I-cache refill port and the D-cache refill/writeback port share
//   one block memory. The winning request is registered at grant time and
//   driven to the memory. The memory's ready/done is returned only to the
//   winner.
//
// Handshake
//   Each requester raises its request (i_ren, d_ren, d_wen) and holds it,
//   with a stable address and data, until its one-cycle completion pulse
//   (i_ready, d_ready, d_done). The request is dropped before the next edge.
//   The arbiter raises mem_ren or mem_wen one cycle after the grant. It holds
//   the strobe, address and data until the matching mem_ready or mem_done
//   pulse. Completion pulses are combinational from the memory.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   i_ren, i_block_address, i_ready, i_dout          I-side read port
//   d_ren, d_wen, d_block_address, d_din,
//   d_ready, d_done, d_dout                          D-side read/write port
//   mem_ren, mem_wen, mem_block_address, mem_din,
//   mem_ready, mem_done, mem_dout                    unified memory port
//   dbg_state           FSM state: 0 = IDLE, 1 = SERVE_I, 2 = SERVE_D
//
// Configuration macros
//   ARB_RR_EN           When an I request and a D request arrive together,
//                       the grant alternates. When the macro is undefined,
//                       D always wins.
//   MEM_ARB_SIM_CHECKS  Simulation only. Reports an error when d_ren and
//                       d_wen are both high at grant.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_ren,
  input  logic [ADDR_W-1:0]  i_block_address,
  output logic               i_ready,
  output logic [BLOCK_W-1:0] i_dout,
  input  logic               d_ren,
  input  logic               d_wen,
  input  logic [ADDR_W-1:0]  d_block_address,
  input  logic [BLOCK_W-1:0] d_din,
  output logic               d_ready,
  output logic               d_done,
  output logic [BLOCK_W-1:0] d_dout,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_block_address,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic               mem_ready,
  input  logic               mem_done,
  input  logic [BLOCK_W-1:0] mem_dout,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 mem_ren_q, mem_ren_d;
  logic                 mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   din_q, din_d;

  logic                 i_req, d_req;
  logic                 grant_i, grant_d;
  logic                 complete;

`ifdef ARB_RR_EN
  // 1 means the most recent grant went to D. Reset value is 0 (last = I).
  logic                 last_d_q, last_d_d;
`endif

  assign i_req = i_ren;
  assign d_req = d_ren | d_wen;

  // Grants are only issued from IDLE. While an op is in flight, requester
  // inputs are ignored and everything is taken from the latched registers.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
`ifdef ARB_RR_EN
        grant_d = ~last_d_q;
        grant_i = last_d_q;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // A completion counts only when it matches the op in flight. A stray pulse
  // in IDLE, or a pulse of the wrong type, has no effect.
  assign complete = (mem_ren_q & mem_ready) | (mem_wen_q & mem_done);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
`ifdef ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
`ifdef ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    mem_ren_d = mem_ren_q;
    mem_wen_d = mem_wen_q;
    addr_d    = addr_q;
    din_d     = din_q;
`ifdef ARB_RR_EN
    last_d_d  = last_d_q;
    if (grant_d) begin
      last_d_d = 1'b1;
    end else if (grant_i) begin
      last_d_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d   = SERVE_I;
          mem_ren_d = 1'b1;
          mem_wen_d = 1'b0;
          addr_d    = i_block_address;
        end else if (grant_d) begin
          // When d_ren and d_wen are both high, the write wins.
          state_d   = SERVE_D;
          mem_ren_d = ~d_wen;
          mem_wen_d = d_wen;
          addr_d    = d_block_address;
          if (d_wen) begin
            din_d = d_din;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (complete) begin
          state_d   = IDLE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // Output logic: completions are routed to the winner only.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    d_done  = 1'b0;
    case (state_q)
      SERVE_I: i_ready = mem_ren_q & mem_ready;
      SERVE_D: begin
        d_ready = mem_ren_q & mem_ready;
        d_done  = mem_wen_q & mem_done;
      end
      default: ;
    endcase
  end

  assign mem_ren           = mem_ren_q;
  assign mem_wen           = mem_wen_q;
  assign mem_block_address = addr_q;
  assign mem_din           = din_q;
  assign i_dout            = mem_dout;
  assign d_dout            = mem_dout;
  assign dbg_state         = state_q;

`ifdef MEM_ARB_SIM_CHECKS
  always @(posedge clock) begin
    if (reset && state_q == IDLE && grant_d && d_ren && d_wen) begin
      $error("mem_arbiter: d_ren and d_wen both high; write served");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int BW = 128;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          i_ren, i_ready;
  logic [AW-1:0] i_block_address;
  logic [BW-1:0] i_dout;
  logic          d_ren, d_wen, d_ready, d_done;
  logic [AW-1:0] d_block_address;
  logic [BW-1:0] d_din, d_dout;
  logic          mem_ren, mem_wen, mem_ready, mem_done;
  logic [AW-1:0] mem_block_address;
  logic [BW-1:0] mem_din, mem_dout;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clock(clock), .reset(reset),
    .i_ren(i_ren), .i_block_address(i_block_address), .i_ready(i_ready), .i_dout(i_dout),
    .d_ren(d_ren), .d_wen(d_wen), .d_block_address(d_block_address), .d_din(d_din),
    .d_ready(d_ready), .d_done(d_done), .d_dout(d_dout),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_block_address(mem_block_address),
    .mem_din(mem_din), .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] mem_arr [0:1023];   // contents of the memory model
  logic [BW-1:0] ref_mem [0:1023];   // reference: what the memory should hold
  logic [BW-1:0] exp_q[$];           // expected read data
  int  fixed_lat = 0;                // 0 = random latency 1..4
  bit  model_last_d = 1'b0;          // reference arbiter: last grant went to D
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- memory model ----------------
  // Updates 1 time unit after each rising edge. It pulses mem_ready or
  // mem_done for one cycle once the strobe has been high for 'lat' cycles.
  initial begin : memory_model
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    mem_dout  = '0;
    forever begin
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      mem_done  = 1'b0;
      if (reset !== 1'b1 || !(mem_ren || mem_wen)) begin
        cnt = 0;
      end else begin
        if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        cnt++;
        if (cnt >= lat) begin
          if (mem_wen) begin
            mem_arr[mem_block_address] = mem_din;
            mem_done = 1'b1;
          end else begin
            mem_dout  = mem_arr[mem_block_address];
            mem_ready = 1'b1;
          end
          cnt = 0;
        end
      end
    end
  end

  // At most one completion pulse is visible in any cycle.
  always @(negedge clock) begin
    if (reset === 1'b1 && (i_ready || d_ready || d_done)) begin
      check("single_pulse", BW'(i_ready) + BW'(d_ready) + BW'(d_done), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic i_txn(input logic [AW-1:0] a);
    int n;
    i_block_address = a;
    i_ren = 1'b1;
    exp_q.push_back(ref_mem[a]);
    n = 0;
    while (i_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("i_ready_seen", i_ready, 1);
    check("i_read_data", i_dout, exp_q.pop_front());
    i_ren = 1'b0;
    model_last_d = 1'b0;
    @(negedge clock);
  endtask

  task automatic d_txn(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] data);
    int n;
    logic [BW-1:0] exp_data;
    d_block_address = a;
    d_din = data;
    d_wen = wr;
    d_ren = ~wr;
    exp_data = ref_mem[a];
    n = 0;
    while (d_ready !== 1'b1 && d_done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (wr) begin
      check("d_done_seen", d_done, 1);
      ref_mem[a] = data;
    end else begin
      check("d_ready_seen", d_ready, 1);
      check("d_read_data", d_dout, exp_data);
    end
    d_ren = 1'b0;
    d_wen = 1'b0;
    model_last_d = 1'b1;
    @(negedge clock);
  endtask

  // Raise I and D read requests in the same cycle. Check which one is served
  // first against the reference arbitration rule.
  task automatic tie_round(input string tag);
    int n;
    int order[$];
    bit i_pend, d_pend;
    int exp_first;
    logic [BW-1:0] exp_i, exp_d;
    logic [AW-1:0] ai, ad;
    ai = AW'($urandom_range(0, 511));
    ad = AW'($urandom_range(512, 1023));
    exp_i = ref_mem[ai];
    exp_d = ref_mem[ad];
    exp_first = (!RR || !model_last_d) ? 1 : 0;  // 1 = D, 0 = I
    i_block_address = ai;
    d_block_address = ad;
    i_ren = 1'b1;
    d_ren = 1'b1;
    i_pend = 1'b1;
    d_pend = 1'b1;
    n = 0;
    while ((i_pend || d_pend) && n < 200) begin
      @(negedge clock);
      n++;
      if (i_pend && i_ready === 1'b1) begin
        order.push_back(0);
        check({tag, "_i_data"}, i_dout, exp_i);
        i_ren = 1'b0;
        i_pend = 1'b0;
      end
      if (d_pend && d_ready === 1'b1) begin
        order.push_back(1);
        check({tag, "_d_data"}, d_dout, exp_d);
        d_ren = 1'b0;
        d_pend = 1'b0;
      end
    end
    i_ren = 1'b0;
    d_ren = 1'b0;
    check({tag, "_both_served"}, BW'(order.size()), 2);
    if (order.size() == 2) begin
      check({tag, "_first"}, BW'(order[0]), BW'(exp_first));
      model_last_d = (order[1] == 1);
    end
    @(negedge clock);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [BW-1:0] pat;
    logic [BW-1:0] v;
    int n;
    reset = 1'b0;
    i_ren = 1'b0; i_block_address = '0;
    d_ren = 1'b0; d_wen = 1'b0; d_block_address = '0; d_din = '0;
    for (int k = 0; k < 1024; k++) begin
      v = rnd_block();
      mem_arr[k] = v;
      ref_mem[k] = v;
    end
    mem_arr[10'h012] = 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF;
    ref_mem[10'h012] = 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_d_done", d_done, 0);
    check("rst_mem_addr", mem_block_address, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    model_last_d = 1'b0;
    @(negedge clock);

    // I read, address 0x012, 3-cycle memory latency
    fixed_lat = 3;
    i_block_address = 10'h012;
    i_ren = 1'b1;
    #1 check("i_grant_not_yet", mem_ren, 0);
    @(negedge clock);
    check("i_mem_ren", mem_ren, 1);
    check("i_mem_addr", mem_block_address, 10'h012);
    check("i_state", dbg_state, 1);
    n = 0;
    while (i_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("i_ready_pulse", i_ready, 1);
    check("i_read_latency", BW'(n), 2);
    check("i_dout", i_dout, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);
    check("i_d_ready_quiet", d_ready, 0);
    i_ren = 1'b0;
    model_last_d = 1'b0;
    @(negedge clock);
    check("i_ready_width", i_ready, 0);
    check("i_back_idle", dbg_state, 0);

    // D write to 0x3FF. Address and data change while the write is held.
    pat = {16{8'hA5}};
    d_block_address = 10'h3FF;
    d_din = pat;
    d_wen = 1'b1;
    @(negedge clock);
    check("dw_mem_wen", mem_wen, 1);
    check("dw_mem_ren", mem_ren, 0);
    check("dw_mem_din", mem_din, pat);
    check("dw_mem_addr", mem_block_address, 10'h3FF);
    d_block_address = 10'h000;
    d_din = '0;
    @(negedge clock);
    check("dw_addr_held", mem_block_address, 10'h3FF);
    check("dw_din_held", mem_din, pat);
    n = 0;
    while (d_done !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("dw_done", d_done, 1);
    check("dw_no_d_ready", d_ready, 0);
    check("dw_no_i_ready", i_ready, 0);
    d_wen = 1'b0;
    ref_mem[10'h3FF] = pat;
    model_last_d = 1'b1;
    @(negedge clock);
    check("dw_done_width", d_done, 0);
    check("dw_stored", mem_arr[10'h3FF], ref_mem[10'h3FF]);

    // Reset in the middle of a D write
    fixed_lat = 20;
    d_block_address = 10'h100;
    d_din = rnd_block();
    d_wen = 1'b1;
    repeat (2) @(negedge clock);
    check("rmid_mem_wen", mem_wen, 1);
    check("rmid_state", dbg_state, 2);
    reset = 1'b0;
    #1;
    check("rmid_wen_drop", mem_wen, 0);
    check("rmid_idle", dbg_state, 0);
    check("rmid_no_done", d_done, 0);
    d_wen = 1'b0;
    model_last_d = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rmid_after_done", d_done, 0);
    check("rmid_after_wen", mem_wen, 0);
    check("rmid_not_written", mem_arr[10'h100], ref_mem[10'h100]);
    fixed_lat = 0;

    // Simultaneous requests, twice, with a lone D read in between
    tie_round("tie1");
    d_txn(1'b0, AW'($urandom_range(512, 1023)), '0);
    tie_round("tie2");

    // d_ren and d_wen together: the write is served
    v = rnd_block();
    d_block_address = 10'h040;
    d_din = v;
    d_ren = 1'b1;
    d_wen = 1'b1;
    n = 0;
    while (d_done !== 1'b1 && d_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rw_done", d_done, 1);
    check("rw_no_ready", d_ready, 0);
    d_ren = 1'b0;
    d_wen = 1'b0;
    ref_mem[10'h040] = v;
    @(negedge clock);
    check("rw_stored", mem_arr[10'h040], ref_mem[10'h040]);

    // Stray memory pulses while IDLE
    mem_ready = 1'b1;
    #1;
    check("spur_rdy_i", i_ready, 0);
    check("spur_rdy_d", d_ready, 0);
    @(negedge clock);
    check("spur_rdy_state", dbg_state, 0);
    check("spur_rdy_ren", mem_ren, 0);
    mem_done = 1'b1;
    #1;
    check("spur_done_d", d_done, 0);
    @(negedge clock);
    check("spur_done_state", dbg_state, 0);
    check("spur_done_wen", mem_wen, 0);

    // Random concurrent traffic: I reads the low half, D reads and writes the
    // high half. A lost request shows up as a timeout.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clock);
          i_txn(AW'($urandom_range(0, 511)));
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clock);
          d_txn(1'($urandom_range(0, 1)), AW'($urandom_range(512, 1023)), rnd_block());
        end
      end
    join
    for (int k = 512; k < 1024; k += 37) begin
      check("final_mem", mem_arr[k], ref_mem[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
